// File: rtl/fft_bitrev_reorder_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bitrev_reorder_if
//  Description : Stream bundle for the FFT bit-reversal reorder block.
//                di_* carry FFT results in bit-reversed order into the block;
//                do_* carry the same samples out in natural bin order.
//                  di_en    : input sample valid
//                  di_re/im : input real / imaginary part (WIDTH bits each)
//                  do_en    : output sample valid
//                  do_re/im : output real / imaginary part (WIDTH bits each)
//                  do_index : bin number of the current output sample
//                  do_last  : high with do_en on bin N-1
//                master : drives di_*, observes do_* (upstream + downstream)
//                slave  : the reorder block itself
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_bitrev_reorder_if #(
   parameter int WIDTH = 32,
   parameter int LOG2N = 9
);
   logic             di_en;
   logic [WIDTH-1:0] di_re;
   logic [WIDTH-1:0] di_im;
   logic             do_en;
   logic [WIDTH-1:0] do_re;
   logic [WIDTH-1:0] do_im;
   logic [LOG2N-1:0] do_index;
   logic             do_last;

   modport master (
      output di_en, di_re, di_im,
      input  do_en, do_re, do_im, do_index, do_last
   );

   modport slave (
      input  di_en, di_re, di_im,
      output do_en, do_re, do_im, do_index, do_last
   );
endinterface
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bitrev_reorder
//  Description : Reorders an N-point FFT result stream from bit-reversed order
//                to natural bin order using two ping-pong frame banks, so that
//                back-to-back frames stream through at one sample per clock.
//  Ports       : clock - single master clock
//                reset - synchronous, active-high reset
//                bus   - fft_bitrev_reorder_if.slave (di_* in, do_* out)
//  Revision    : 1.0  initial release
// ============================================================================
module fft_bitrev_reorder #(
   parameter int WIDTH = 32,
   parameter int N     = 512,
   parameter int LOG2N = 9
) (
   input  logic                  clock,
   input  logic                  reset,
   fft_bitrev_reorder_if.slave   bus
);

   localparam logic [LOG2N-1:0] LAST_ADDR = LOG2N'(N - 1);

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Writer: scatters each incoming sample to its natural-order address.
   // ------------------------------------------------------------------------
   logic [LOG2N-1:0] wcnt;
   logic             wbank;
   logic             wrap;

   assign wrap = bus.di_en && (wcnt == LAST_ADDR);

   always_ff @(posedge clock) begin
      if (reset) begin
         wcnt  <= '0;
         wbank <= 1'b0;
      end else if (bus.di_en) begin
         wcnt <= wcnt + LOG2N'(1);
         if (wrap) begin
            wbank <= ~wbank;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Bank-full flags. The next-state value is also what the reader looks at,
   // so a frame completing this cycle is seen without a one-cycle bubble.
   // Writer set and reader clear always target different banks, so both
   // updates apply when they coincide.
   // ------------------------------------------------------------------------
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   state_t           state;
   logic [LOG2N-1:0] rcnt;
   logic             rbank;
   logic [1:0]       full;
   logic [1:0]       full_next;
   logic             rd_last_issue;

   assign rd_last_issue = (state == READ) && (rcnt == LAST_ADDR);

   always_comb begin
      full_next = full;
      if (rd_last_issue) begin
         full_next[rbank] = 1'b0;
      end
      if (wrap) begin
         full_next[wbank] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full <= 2'b00;
      end else begin
         full <= full_next;
      end
   end

   // ------------------------------------------------------------------------
   // Reader FSM. Being in READ is itself the read strobe: one read per cycle
   // at rcnt, no backpressure. Entering READ on the edge where the frame
   // completes puts the read of address 0 in the very next cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         rcnt  <= '0;
         rbank <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rcnt <= '0;
               if (full_next[rbank]) begin
                  state <= READ;
               end
            end
            READ: begin
               rcnt <= rcnt + LOG2N'(1);
               if (rcnt == LAST_ADDR) begin
                  rbank <= ~rbank;
                  // Other bank already holds (or is just completing) a
                  // frame: keep streaming with rcnt wrapping to 0.
                  if (!full_next[~rbank]) begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Frame banks: one write port, one registered read port each.
   // ------------------------------------------------------------------------
   logic [2*WIDTH-1:0] bank_q [2];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [2*WIDTH-1:0] mem [N];
      logic [2*WIDTH-1:0] rdata;

      always_ff @(posedge clock) begin
         if (bus.di_en && (wbank == 1'(b))) begin
            mem[bitrev(wcnt)] <= {bus.di_re, bus.di_im};
         end
         if ((state == READ) && (rbank == 1'(b))) begin
            rdata <= mem[rcnt];
         end
      end

      assign bank_q[b] = rdata;
   end

   // ------------------------------------------------------------------------
   // Output pipeline: control delayed one cycle to line up with RAM data,
   // then everything registered onto do_*.
   // ------------------------------------------------------------------------
   logic             rd_valid_d;
   logic [LOG2N-1:0] rd_index_d;
   logic             rd_last_d;
   logic             rd_bank_d;
   logic [2*WIDTH-1:0] rd_word;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid_d <= 1'b0;
         rd_index_d <= '0;
         rd_last_d  <= 1'b0;
         rd_bank_d  <= 1'b0;
      end else begin
         rd_valid_d <= (state == READ);
         rd_index_d <= rcnt;
         rd_last_d  <= rd_last_issue;
         rd_bank_d  <= rbank;
      end
   end

   assign rd_word = rd_bank_d ? bank_q[1] : bank_q[0];

   logic             out_en;
   logic [WIDTH-1:0] out_re;
   logic [WIDTH-1:0] out_im;
   logic [LOG2N-1:0] out_index;
   logic             out_last;

   // Data and index hold their last values while do_en is low.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_en    <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
      end else begin
         out_en   <= rd_valid_d;
         out_last <= rd_valid_d && rd_last_d;
         if (rd_valid_d) begin
            out_re    <= rd_word[2*WIDTH-1:WIDTH];
            out_im    <= rd_word[WIDTH-1:0];
            out_index <= rd_index_d;
         end
      end
   end

   assign bus.do_en    = out_en;
   assign bus.do_re    = out_re;
   assign bus.do_im    = out_im;
   assign bus.do_index = out_index;
   assign bus.do_last  = out_last;

endmodule
`default_nettype wire
